// File: rtl/song_menu_ctrl.sv
// Song-selection menu and per-song high-score controller for the Recorder Hero front end.
// Runs the MENU -> PLAY -> RESULT flow from rising edges of the debounced buttons.
module song_menu_ctrl #(
  parameter int NUM_SONGS = 4,
  parameter int SCORE_W   = 18,
  parameter int ASCII_W   = 48,
  parameter int WRAP      = 0,
  parameter int SEL_W     = $clog2(NUM_SONGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               enter,
  input  logic               back,
  input  logic               clear_scores,
  input  logic               done,
  input  logic [SCORE_W-1:0] score_bin,
  input  logic [ASCII_W-1:0] score_ascii,
  output logic [SEL_W-1:0]   menu_sel,
  output logic [1:0]         state_out,
  output logic               start_pulse,
  output logic [SEL_W-1:0]   song,
  output logic [ASCII_W-1:0] high_score_ascii,
  output logic [SCORE_W-1:0] high_score_bin,
  output logic               new_record
);

  typedef enum logic [1:0] {
    ST_MENU   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_RESULT = 2'b10
  } state_e;

  localparam logic [ASCII_W-1:0] ZERO_ASCII = ASCII_W'({(ASCII_W/8){8'h30}});
  localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(NUM_SONGS - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     menu_sel_q, menu_sel_d;
  logic [SEL_W-1:0]     song_q, song_d;
  logic                 start_q, start_d;
  logic                 new_rec_q, new_rec_d;
  logic [SCORE_W-1:0]   hs_bin_q, hs_bin_d;
  logic [ASCII_W-1:0]   hs_ascii_q, hs_ascii_d;
  logic                 up_q, down_q, enter_q, back_q;
  logic [SEL_W-1:0]     disp_idx;
  logic                 up_ev, down_ev, enter_ev, back_ev;

  // The score table survives reset; its power-up contents equal the cleared state.
  logic [SCORE_W-1:0] tbl_bin_q   [NUM_SONGS] = '{default: '0};
  logic [ASCII_W-1:0] tbl_ascii_q [NUM_SONGS] = '{default: ZERO_ASCII};
  logic [SCORE_W-1:0] tbl_bin_d   [NUM_SONGS];
  logic [ASCII_W-1:0] tbl_ascii_d [NUM_SONGS];

  assign up_ev    = up & ~up_q;
  assign down_ev  = down & ~down_q;
  assign enter_ev = enter & ~enter_q;
  assign back_ev  = back & ~back_q;

  always_comb begin
    state_d     = state_q;
    menu_sel_d  = menu_sel_q;
    song_d      = song_q;
    start_d     = 1'b0;
    new_rec_d   = new_rec_q;
    tbl_bin_d   = tbl_bin_q;
    tbl_ascii_d = tbl_ascii_q;
    disp_idx    = (state_q == ST_MENU) ? menu_sel_q : song_q;
    hs_bin_d    = tbl_bin_q[disp_idx];
    hs_ascii_d  = tbl_ascii_q[disp_idx];

    case (state_q)
      ST_MENU: begin
        if (clear_scores) begin
          for (int i = 0; i < NUM_SONGS; i++) begin
            tbl_bin_d[i]   = '0;
            tbl_ascii_d[i] = ZERO_ASCII;
          end
        end else begin
          tbl_bin_d = tbl_bin_q;
        end
        // Enter wins over a simultaneous move; up+down together cancel.
        if (enter_ev) begin
          song_d  = menu_sel_q;
          start_d = 1'b1;
          state_d = ST_PLAY;
        end else if (up_ev && !down_ev) begin
          if (menu_sel_q == '0) menu_sel_d = (WRAP != 0) ? LAST_SEL : '0;
          else                  menu_sel_d = menu_sel_q - SEL_W'(1);
        end else if (down_ev && !up_ev) begin
          if (menu_sel_q == LAST_SEL) menu_sel_d = (WRAP != 0) ? '0 : LAST_SEL;
          else                        menu_sel_d = menu_sel_q + SEL_W'(1);
        end else begin
          menu_sel_d = menu_sel_q;
        end
      end
      ST_PLAY: begin
        if (done) begin
          if (score_bin > tbl_bin_q[song_q]) begin
            tbl_bin_d[song_q]   = score_bin;
            tbl_ascii_d[song_q] = score_ascii;
            new_rec_d           = 1'b1;
          end else begin
            new_rec_d = 1'b0;
          end
          state_d = ST_RESULT;
        end else if (back_ev) begin
          new_rec_d = 1'b0;
          state_d   = ST_MENU;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_RESULT: begin
        if (enter_ev) begin
          menu_sel_d = song_q;
          new_rec_d  = 1'b0;
          state_d    = ST_MENU;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_MENU;
      menu_sel_q <= '0;
      song_q     <= '0;
      start_q    <= 1'b0;
      new_rec_q  <= 1'b0;
      hs_bin_q   <= '0;
      hs_ascii_q <= ZERO_ASCII;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      enter_q    <= 1'b0;
      back_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      menu_sel_q <= menu_sel_d;
      song_q     <= song_d;
      start_q    <= start_d;
      new_rec_q  <= new_rec_d;
      hs_bin_q   <= hs_bin_d;
      hs_ascii_q <= hs_ascii_d;
      up_q       <= up;
      down_q     <= down;
      enter_q    <= enter;
      back_q     <= back;
    end
  end

  // Reset leaves the table untouched, including any done arriving with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tbl_bin_q   <= tbl_bin_d;
      tbl_ascii_q <= tbl_ascii_d;
    end else begin
      tbl_bin_q   <= tbl_bin_q;
      tbl_ascii_q <= tbl_ascii_q;
    end
  end

  assign menu_sel         = menu_sel_q;
  assign state_out        = state_q;
  assign start_pulse      = start_q;
  assign song             = song_q;
  assign high_score_bin   = hs_bin_q;
  assign high_score_ascii = hs_ascii_q;
  assign new_record       = new_rec_q;

endmodule
